// File: rtl/down_timer_if.sv
// down_timer_if: control/status bundle between a controller and down_timer
//   load/load_val/en/stop/auto_reload : controller -> timer
//   out/busy/tc                       : timer -> controller
interface down_timer_if #(parameter int WIDTH = 4);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             tc;
  modport master (output load, load_val, en, stop, auto_reload, input out, busy, tc);
  modport slave  (input load, load_val, en, stop, auto_reload, output out, busy, tc);
endinterface

// File: rtl/down_timer.sv
// down_timer: loadable down-counter with one-cycle terminal-count pulse and optional auto-reload
//   clk : rising-edge clock
//   res : asynchronous active-high reset
//   bus : down_timer_if slave (load, load_val, en, stop, auto_reload in; out, busy, tc out)
module down_timer #(parameter int WIDTH = 4) (
  input logic         clk,
  input logic         res,
  down_timer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             w_term;
  logic             w_load_zero;
  // terminal decrement happens from 1; 0 is folded in so the count can never wrap
  assign w_term      = r_out[WIDTH-1:1] == '0;
  assign w_load_zero = bus.load_val == '0;
  always_ff @(posedge clk or posedge res)
    if (res) begin
      r_state  <= IDLE;
      r_out    <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (bus.stop) r_state <= IDLE;
      else if (bus.load) begin
        r_out    <= bus.load_val;
        r_reload <= bus.load_val;
        r_state  <= w_load_zero ? IDLE : RUN;
        r_tc     <= w_load_zero;
      end else if (r_state == RUN && bus.en) begin
        r_out   <= w_term ? (bus.auto_reload ? r_reload : '0) : r_out - WIDTH'(1);
        r_state <= (w_term && !bus.auto_reload) ? IDLE : RUN;
        r_tc    <= w_term;
      end
    end
  assign bus.out  = r_out;
  assign bus.busy = r_state == RUN;
  assign bus.tc   = r_tc;
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: randomized and directed checks of down_timer against a behavioural model
module tb_down_timer;
  localparam int WIDTH = 4;
  logic clk = 1'b0;
  logic res = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] m_out = '0;
  logic [WIDTH-1:0] m_rel = '0;
  logic m_busy = 1'b0;
  logic m_tc = 1'b0;
  down_timer_if #(.WIDTH(WIDTH)) ifc ();
  down_timer #(.WIDTH(WIDTH)) dut (.clk(clk), .res(res), .bus(ifc.slave));
  always #5 clk = ~clk;

  task automatic drive(input logic ld, input int val, input logic e, input logic st, input logic ar);
    ifc.load = ld;
    ifc.load_val = WIDTH'(val);
    ifc.en = e;
    ifc.stop = st;
    ifc.auto_reload = ar;
  endtask

  // Model works on the count as a number: stop halts, load restarts, an enabled
  // cycle removes one unit and reaching zero fires tc and optionally refills.
  task automatic tick();
    @(posedge clk);
    m_tc = 1'b0;
    if (ifc.stop) m_busy = 1'b0;
    else if (ifc.load) begin
      m_out = ifc.load_val;
      m_rel = ifc.load_val;
      m_busy = ifc.load_val != 0;
      m_tc = ifc.load_val == 0;
    end else if (m_busy && ifc.en) begin
      m_out = m_out - 1;
      if (m_out == 0) begin
        m_tc = 1'b1;
        if (ifc.auto_reload) m_out = m_rel;
        else m_busy = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 5, 1, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    tick();
    #2 res = 1'b1;
    m_out = '0; m_rel = '0; m_busy = 1'b0; m_tc = 1'b0;
    #1;
    vectors++;
    if ({ifc.out, ifc.busy, ifc.tc} !== {WIDTH'(0), 2'b00}) begin
      miscompares++;
      $display("FAIL reset_async out=%0d busy=%0b tc=%0b expected 0 0 0", ifc.out, ifc.busy, ifc.tc);
    end
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if ({ifc.out, ifc.busy, ifc.tc} !== {WIDTH'(0), 2'b00}) begin
        miscompares++;
        $display("FAIL reset_hold out=%0d busy=%0b tc=%0b expected 0 0 0", ifc.out, ifc.busy, ifc.tc);
      end
    end
    res = 1'b0;
    repeat (3) begin
      tick();
      vectors++;
      if ({ifc.out, ifc.busy, ifc.tc} !== {m_out, m_busy, m_tc}) begin
        miscompares++;
        $display("FAIL reset_release out=%0d busy=%0b tc=%0b expected %0d %0b %0b", ifc.out, ifc.busy, ifc.tc, m_out, m_busy, m_tc);
      end
    end
  endtask

  task automatic test_one_shot();
    int exp_seq[6] = '{5, 4, 3, 2, 1, 0};
    drive(1, 5, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      drive(0, 0, 1, 0, 0);
      vectors++;
      if ({ifc.out, ifc.busy, ifc.tc} !== {m_out, m_busy, m_tc} || ifc.out !== WIDTH'(exp_seq[i]) || ifc.tc !== (i == 5) || ifc.busy !== (i != 5)) begin
        miscompares++;
        $display("FAIL one_shot step%0d out=%0d busy=%0b tc=%0b expected %0d %0b %0b", i, ifc.out, ifc.busy, ifc.tc, exp_seq[i], i != 5, i == 5);
      end
    end
  endtask

  task automatic test_auto_reload();
    int pulses = 0;
    drive(1, 3, 1, 0, 1);
    tick();
    drive(0, 0, 1, 0, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      pulses += int'(ifc.tc);
      vectors++;
      if ({ifc.out, ifc.busy, ifc.tc} !== {m_out, m_busy, m_tc} || ifc.out !== WIDTH'(2 - (i % 3) == 0 ? 3 : 2 - (i % 3))) begin
        miscompares++;
        $display("FAIL auto_reload step%0d out=%0d busy=%0b tc=%0b expected %0d %0b %0b", i, ifc.out, ifc.busy, ifc.tc, m_out, m_busy, m_tc);
      end
    end
    vectors++;
    if (pulses != 4 || ifc.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL auto_reload_pulses got=%0d busy=%0b expected 4 1", pulses, ifc.busy);
    end
    drive(0, 0, 0, 1, 0);
    tick();
  endtask

  task automatic test_enable_gaps();
    drive(1, 4, 0, 0, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, (i % 2) == 0, 0, 0);
      tick();
      vectors++;
      if ({ifc.out, ifc.busy, ifc.tc} !== {m_out, m_busy, m_tc} || ifc.tc !== (i == 6)) begin
        miscompares++;
        $display("FAIL enable_gaps step%0d out=%0d busy=%0b tc=%0b expected %0d %0b %0b", i, ifc.out, ifc.busy, ifc.tc, m_out, m_busy, m_tc);
      end
    end
  endtask

  task automatic test_priority();
    drive(1, 4, 1, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    tick();
    tick();
    drive(0, 0, 1, 1, 0);
    tick();
    vectors++;
    if ({ifc.out, ifc.busy, ifc.tc} !== {WIDTH'(2), 2'b00} || {m_out, m_busy, m_tc} !== {WIDTH'(2), 2'b00}) begin
      miscompares++;
      $display("FAIL stop_hold out=%0d busy=%0b tc=%0b expected 2 0 0", ifc.out, ifc.busy, ifc.tc);
    end
    drive(1, 1, 1, 0, 0);
    tick();
    drive(1, 9, 1, 0, 0);
    tick();
    vectors++;
    if ({ifc.out, ifc.busy, ifc.tc} !== {WIDTH'(9), 2'b10}) begin
      miscompares++;
      $display("FAIL load_on_terminal out=%0d busy=%0b tc=%0b expected 9 1 0", ifc.out, ifc.busy, ifc.tc);
    end
    drive(1, 7, 1, 1, 0);
    tick();
    vectors++;
    if ({ifc.out, ifc.busy, ifc.tc} !== {WIDTH'(9), 2'b00}) begin
      miscompares++;
      $display("FAIL stop_beats_load out=%0d busy=%0b tc=%0b expected 9 0 0", ifc.out, ifc.busy, ifc.tc);
    end
  endtask

  task automatic test_boundaries();
    drive(1, 0, 1, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    vectors++;
    if ({ifc.out, ifc.busy, ifc.tc} !== {WIDTH'(0), 2'b01}) begin
      miscompares++;
      $display("FAIL load_zero out=%0d busy=%0b tc=%0b expected 0 0 1", ifc.out, ifc.busy, ifc.tc);
    end
    tick();
    vectors++;
    if ({ifc.out, ifc.busy, ifc.tc} !== {WIDTH'(0), 2'b00}) begin
      miscompares++;
      $display("FAIL load_zero_after out=%0d busy=%0b tc=%0b expected 0 0 0", ifc.out, ifc.busy, ifc.tc);
    end
    drive(1, 15, 1, 0, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    for (int i = 1; i <= 18; i++) begin
      tick();
      vectors++;
      if ({ifc.out, ifc.busy, ifc.tc} !== {m_out, m_busy, m_tc} || ifc.tc !== (i == 15) || ifc.out !== WIDTH'(i >= 15 ? 0 : 15 - i)) begin
        miscompares++;
        $display("FAIL max_load step%0d out=%0d busy=%0b tc=%0b expected %0d %0b %0b", i, ifc.out, ifc.busy, ifc.tc, m_out, m_busy, m_tc);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 1));
      tick();
      vectors++;
      if ({ifc.out, ifc.busy, ifc.tc} !== {m_out, m_busy, m_tc}) begin
        miscompares++;
        $display("FAIL random cyc%0d out=%0d busy=%0b tc=%0b expected %0d %0b %0b", i, ifc.out, ifc.busy, ifc.tc, m_out, m_busy, m_tc);
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_enable_gaps();
    test_priority();
    test_boundaries();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/down_timer.md
# down_timer

Loadable, parameter-width down-counter/timer with a terminal-count pulse and optional auto-reload. It complements the up-counting 4-bit counter in the same library. A controller loads a start value, and the block counts toward zero on each enabled cycle. It flags terminal count so periodic ticks, timeouts and delay intervals can be generated. It sits beside the free-running counter in the same clock domain.

## Interface
- `WIDTH`, default 4: counter and load-value width in bits; legal range 2..16.
- `clk` input 1: clock; all state updates on the rising edge.
- `res` input 1: asynchronous, active-high reset.
- `load` input 1: load `load_val` into the counter and the reload register; starts a run.
- `load_val` input WIDTH: start value; unsigned.
- `en` input 1: count enable; one decrement per cycle while high in RUN.
- `stop` input 1: abort the run; return to IDLE and hold `out`.
- `auto_reload` input 1: when high at terminal count, restart from the reload register.
- `out` output WIDTH: current count; registered.
- `busy` output 1: high in RUN; registered.
- `tc` output 1: terminal-count pulse, exactly one cycle; registered.

## Operation
- Reset (`res`=1, asynchronous): `out`=0, reload register=0, state=IDLE, `busy`=0, `tc`=0. All outputs hold these values for as long as `res` is high.
- States are IDLE and RUN. `busy`=1 only in RUN.
- Per-edge priority is `stop` > `load` > decrement.
- `stop`=1: state becomes IDLE and `out` holds its value. `tc`=0 that cycle, even if a terminal decrement was due.
- `load`=1 with `load_val`≠0, in either state: `out`=`load_val`, reload register=`load_val`, state becomes RUN, `tc`=0.
- `load`=1 with `load_val`=0: `out`=0, reload register=0, state becomes IDLE, `tc`=1 for one cycle.
- RUN, `en`=1, `out`>1: `out` becomes `out`−1.
- RUN, `en`=1, `out`=1 (terminal decrement): `tc`=1 on the next cycle.
  - If `auto_reload`=1: `out` becomes the reload register value and state stays RUN.
  - If `auto_reload`=0: `out` becomes 0 and state becomes IDLE.
- RUN, `en`=0: `out` holds and `tc`=0.
- IDLE with no `load`: `out` holds and `en` is ignored.
- No wrap-around: `out` never decrements below 0 and never wraps to all-ones.
- `auto_reload` is sampled only on the terminal-decrement edge. Changing it mid-run has no other effect.
- `tc` is 0 on every cycle not listed above.

## Timing
- Load latency is one edge: `load` sampled at edge N gives `out`=`load_val` and `busy`=1 after edge N.
- With `en` held high and load value V≥1 at edge N:
  - `out` steps V−1, …, 1 after edges N+1 … N+V−1.
  - `tc`=1 and `out`=0 (or the reload value) after edge N+V.
  - `busy` falls after edge N+V when `auto_reload`=0.
- Auto-reload period is exactly V enabled cycles between consecutive `tc` pulses.
- `tc` is registered and coincides with the cycle in which `out` shows the post-terminal value.
- `load` on the terminal-decrement edge wins: the new value is loaded, `tc`=0, and the run restarts.
- `res` asserted mid-run: outputs go to reset values immediately, without waiting for a clock edge. The first edge after `res` falls sees IDLE.
- No combinational path from any input to any output.

## Test plan
- Reset: hold `res`=1 for 2 cycles during a run of 5 → `out`=0, `busy`=0 and `tc`=0 immediately; block remains IDLE after release.
- One-shot: `load_val`=5 (WIDTH=4), `en`=1, `auto_reload`=0 → `out` 5,4,3,2,1,0; `tc`=1 on the `out`=0 cycle only; `busy` falls with `tc`.
- Auto-reload: `load_val`=3, `auto_reload`=1, `en`=1 for 12 cycles → `tc` pulses every 3 cycles (4 pulses); `out` sequence 3,2,1,3,2,1,…; `busy` stays 1.
- Enable gaps: `load_val`=4, toggle `en` 1,0,1,0… → `out` decrements only on `en`=1 cycles; `tc` arrives 4 enabled cycles after load.
- Priority:
  - `stop` during a run at `out`=2 → IDLE, `out` holds 2, no `tc`.
  - `load` of 9 on the terminal edge → `out`=9, `tc`=0.
  - `stop` and `load` together → `stop` wins.
- Boundaries:
  - `load_val`=0 → single `tc` pulse, IDLE.
  - WIDTH=4, `load_val`=15 → 15 enabled cycles to `tc`; `out` never wraps to 15 after 0.
